// File: rtl/led_fade_driver.sv
// LED fade driver: turns on/off LED targets into saturating brightness ramps
// and drives each LED with a registered PWM output. Flags when every level
// has reached its target and pulses once on each entry into that state.
module led_fade_driver #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned STEP     = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_LEDS-1:0] leds_in,
    input  logic                bypass,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                settled,
    output logic                settle_pulse
);

    localparam int unsigned          DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0]      DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0]  LevelMax = {PWM_BITS{1'b1}};
    // One extra bit so the saturating add/subtract can detect over/underflow.
    localparam logic [PWM_BITS:0]    StepExt  = (PWM_BITS + 1)'(STEP);

    logic [NUM_LEDS-1:0]                leds_q;
    logic [DivW-1:0]                    presc_q, presc_d;
    logic                               tick;
    logic [PWM_BITS-1:0]                pwm_cnt_q;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q, level_d, target;
    logic [NUM_LEDS-1:0]                at_target;
    logic [PWM_BITS:0]                  up_sum, dn_diff;
    logic [NUM_LEDS-1:0]                led_out_q, led_out_d;
    logic                               settled_q, settled_d;
    logic                               settle_pulse_q;

    // Register the PIO export; everything downstream sees only leds_q.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_in;
        end
    end

    // Ramp prescaler next state: tick on the last count, then wrap.
    always_comb begin
        tick    = (presc_q == DivLast);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler and free-running PWM counter.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // Per-LED target and saturating ramp step; bypass snaps to target.
    always_comb begin
        level_d   = level_q;
        target    = '0;
        at_target = '0;
        up_sum    = '0;
        dn_diff   = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            target[i]    = {PWM_BITS{leds_q[i]}};
            at_target[i] = (level_q[i] == target[i]);
            up_sum       = {1'b0, level_q[i]} + StepExt;
            dn_diff      = {1'b0, level_q[i]} - StepExt;
            if (bypass) begin
                level_d[i] = target[i];
            end else if (tick) begin
                if (leds_q[i]) begin
                    level_d[i] = up_sum[PWM_BITS] ? LevelMax : up_sum[PWM_BITS-1:0];
                end else begin
                    // Top bit set means the subtraction borrowed: clamp at zero.
                    level_d[i] = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
                end
            end
        end
    end

    // Brightness level registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // PWM compare and settle detection, both on pre-update levels.
    always_comb begin
        led_out_d = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (bypass) begin
                led_out_d[i] = leds_q[i];
            end else begin
                // Full level is forced on; a plain compare would leave one dark slot.
                led_out_d[i] = (level_q[i] == LevelMax) || (pwm_cnt_q < level_q[i]);
            end
        end
        settled_d = &at_target;
    end

    // Registered outputs; settled resets high so no pulse fires out of reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_out_q      <= '0;
            settled_q      <= 1'b1;
            settle_pulse_q <= 1'b0;
        end else begin
            led_out_q      <= led_out_d;
            settled_q      <= settled_d;
            settle_pulse_q <= settled_d & ~settled_q;
        end
    end

    assign led_out      = led_out_q;
    assign settled      = settled_q;
    assign settle_pulse = settle_pulse_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4 (MAX=15).
// Main instance: CLK_DIV=4, STEP=1. Extra instances: STEP=4 for the
// saturation case, and CLK_DIV=32 so a level holds long enough to measure duty.
`timescale 1ns/1ps
module tb_led_fade_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_reset, bypass;
    logic [7:0] leds_in, led_out;
    logic       settled, settle_pulse;

    logic       rst4;
    logic [7:0] leds_in4, led_out4;
    logic       settled4, settle_pulse4;

    logic       rst_s;
    logic [7:0] leds_in_s, led_out_s;
    logic       settled_s, settle_pulse_s;

    logic       zero_bypass = 1'b0;

    int checks   = 0;
    int failures = 0;
    int pulses, cnt, bad;

    led_fade_driver #(.NUM_LEDS(8), .PWM_BITS(4), .CLK_DIV(4), .STEP(1)) dut (
        .clk_clk(clk), .reset_reset(reset_reset), .leds_in(leds_in), .bypass(bypass),
        .led_out(led_out), .settled(settled), .settle_pulse(settle_pulse)
    );

    led_fade_driver #(.NUM_LEDS(8), .PWM_BITS(4), .CLK_DIV(4), .STEP(4)) dut4 (
        .clk_clk(clk), .reset_reset(rst4), .leds_in(leds_in4), .bypass(zero_bypass),
        .led_out(led_out4), .settled(settled4), .settle_pulse(settle_pulse4)
    );

    led_fade_driver #(.NUM_LEDS(8), .PWM_BITS(4), .CLK_DIV(32), .STEP(1)) dut_s (
        .clk_clk(clk), .reset_reset(rst_s), .leds_in(leds_in_s), .bypass(zero_bypass),
        .led_out(led_out_s), .settled(settled_s), .settle_pulse(settle_pulse_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with reset_reset high and leds_in=FF; releases reset
    // and follows the full rise to 15 on every LED.
    task automatic rise_from_reset(input string sc);
        int p;
        p = 0;
        check({sc, "_rst_led_out"}, 64'(led_out), 64'h0);
        check({sc, "_rst_settled"}, 64'(settled), 64'h1);
        check({sc, "_rst_pulse"}, 64'(settle_pulse), 64'h0);
        check({sc, "_rst_level"}, 64'(dut.level_q), 64'h0);
        reset_reset = 1'b0;
        for (int e = 1; e <= 62; e++) begin
            @(negedge clk);
            if (settle_pulse) p++;
            if (e == 3)  check({sc, "_lvl_e3"}, 64'(dut.level_q), 64'h0);
            if (e == 4)  check({sc, "_lvl_e4"}, 64'(dut.level_q), 64'h1111_1111);
            if (e == 59) check({sc, "_lvl_e59"}, 64'(dut.level_q), 64'hEEEE_EEEE);
            if (e == 60) begin
                check({sc, "_lvl_e60"}, 64'(dut.level_q), 64'hFFFF_FFFF);
                check({sc, "_settled_e60"}, 64'(settled), 64'h0);
            end
            if (e == 61) check({sc, "_settled_e61"}, 64'(settled), 64'h1);
            if (e == 62) check({sc, "_led_out_full"}, 64'(led_out), 64'hFF);
        end
        check({sc, "_pulse_count"}, 64'(p), 64'd1);
    endtask

    initial begin
        reset_reset = 1'b1;
        bypass      = 1'b0;
        leds_in     = 8'hFF;
        rst4        = 1'b1;
        leds_in4    = 8'h80;
        rst_s       = 1'b1;
        leds_in_s   = 8'h01;
        repeat (3) @(negedge clk);

        // 1: reset then full rise.
        rise_from_reset("s1");

        // 2: target drop makes settled fall; PWM duty at a held level of 5.
        leds_in = 8'h01;
        repeat (3) @(negedge clk);
        check("s2_settled_fall", 64'(settled), 64'h0);

        rst_s = 1'b0;
        cnt   = 0;
        bad   = 0;
        pulses = 0;
        for (int k = 1; k <= 177; k++) begin
            @(negedge clk);
            if (settle_pulse_s) pulses++;
            if (k == 159) check("s2_slow_lvl4", 64'(dut_s.level_q[0]), 64'd4);
            if (k == 160) check("s2_slow_lvl5", 64'(dut_s.level_q[0]), 64'd5);
            if (k >= 162) begin
                if (led_out_s[0]) cnt++;
                if (led_out_s[7:1] != 7'h0) bad++;
            end
        end
        check("s2_duty_5_of_16", 64'(cnt), 64'd5);
        check("s2_other_leds_off", 64'(bad), 64'd0);
        check("s2_slow_settled", 64'(settled_s), 64'h0);
        check("s2_slow_no_pulse", 64'(pulses), 64'd0);

        // 3: ramp LED0 to 8, then reverse down to 0.
        reset_reset = 1'b1;
        leds_in     = 8'h01;
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        repeat (32) @(negedge clk);
        check("s3_lvl8", 64'(dut.level_q), 64'h0000_0008);
        leds_in = 8'h00;
        pulses  = 0;
        for (int e = 33; e <= 72; e++) begin
            @(negedge clk);
            if (settle_pulse) pulses++;
            if (e == 35) check("s3_hold8", 64'(dut.level_q[0]), 64'd8);
            if (e == 36) check("s3_down7", 64'(dut.level_q[0]), 64'd7);
            if (e == 64) begin
                check("s3_zero", 64'(dut.level_q[0]), 64'd0);
                check("s3_settled_e64", 64'(settled), 64'h0);
            end
            if (e == 65) check("s3_settled_e65", 64'(settled), 64'h1);
            if (e == 72) begin
                check("s3_no_underflow", 64'(dut.level_q), 64'h0);
                check("s3_led_out_off", 64'(led_out), 64'h0);
            end
        end
        check("s3_pulse_count", 64'(pulses), 64'd1);

        // 4: STEP=4 saturates at 15.
        rst4   = 1'b0;
        bad    = 0;
        pulses = 0;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            if (settle_pulse4) pulses++;
            if (e == 4)  check("s4_lvl4", 64'(dut4.level_q[7]), 64'd4);
            if (e == 8)  check("s4_lvl8", 64'(dut4.level_q[7]), 64'd8);
            if (e == 12) check("s4_lvl12", 64'(dut4.level_q[7]), 64'd12);
            if (e == 16) check("s4_lvl15", 64'(dut4.level_q[7]), 64'd15);
            if (e == 20) check("s4_lvl15_hold", 64'(dut4.level_q), 64'hF000_0000);
            if (e >= 17 && led_out4 != 8'h80) bad++;
        end
        check("s4_led7_steady", 64'(bad), 64'd0);
        check("s4_settled", 64'(settled4), 64'h1);
        check("s4_pulse_count", 64'(pulses), 64'd1);

        // 5: bypass mid-ramp, then resume fading from snapped levels.
        reset_reset = 1'b1;
        leds_in     = 8'hFF;
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        repeat (10) @(negedge clk);
        check("s5_mid_ramp", 64'(dut.level_q), 64'h2222_2222);
        bypass  = 1'b1;
        leds_in = 8'hA5;
        @(negedge clk);
        check("s5_bypass_e1", 64'(led_out), 64'hFF);
        @(negedge clk);
        check("s5_bypass_e2", 64'(led_out), 64'hA5);
        @(negedge clk);
        check("s5_bypass_settled", 64'(settled), 64'h1);
        check("s5_bypass_level", 64'(dut.level_q), 64'hF0F0_0F0F);
        check("s5_bypass_led_out", 64'(led_out), 64'hA5);
        bypass  = 1'b0;
        leds_in = 8'h5A;
        @(negedge clk);
        check("s5_e14_settled", 64'(settled), 64'h1);
        @(negedge clk);
        check("s5_e15_settled", 64'(settled), 64'h0);
        check("s5_e15_hold", 64'(dut.level_q), 64'hF0F0_0F0F);
        @(negedge clk);
        check("s5_resume", 64'(dut.level_q), 64'hE1E1_1E1E);
        check("s5_led_out_pre_rst", 64'(led_out), 64'hA5);

        // 6: asynchronous reset between edges, then the same rise as 1.
        #2;
        reset_reset = 1'b1;
        leds_in     = 8'hFF;
        #1;
        check("s6_async_led_out", 64'(led_out), 64'h0);
        check("s6_async_level", 64'(dut.level_q), 64'h0);
        check("s6_async_settled", 64'(settled), 64'h1);
        @(negedge clk);
        rise_from_reset("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream consumer of the 8-bit LED PIO export of the Nios system.
- Turns each on/off LED bit into a brightness ramp: level rises toward full when the bit is 1 and falls toward 0 when the bit is 0.
- Drives the board LEDs with per-LED PWM.
- Reports when all LEDs have reached their targets, usable as an interrupt source back into the system.

Parameters:
- NUM_LEDS, 8, number of LED channels.
- PWM_BITS, 8, width of brightness level and PWM counter; MAX = 2^PWM_BITS-1.
- CLK_DIV, 50000, clk_clk cycles per ramp step; legal range >= 1.
- STEP, 1, level change per ramp step; legal range 1..MAX.

Ports:
- clk_clk  input  1  system clock (PLL output domain shared with the PIO).
- reset_reset  input  1  asynchronous, active-high reset.
- leds_in  input  NUM_LEDS  target bits from the LED PIO export, same clock domain.
- bypass  input  1  1 = drive LEDs directly from targets, no fading.
- led_out  output  NUM_LEDS  PWM drive to board LEDs, 1 = lit.
- settled  output  1  1 when every level equals its target.
- settle_pulse  output  1  one-cycle pulse on each 0->1 transition of settled.

Behaviour:
- Reset (async assert, sync release), all state cleared: leds_q=0, prescaler=0, pwm_cnt=0, level[i]=0. Outputs: led_out=0, settled=1, settle_pulse=0.
- Input stage: leds_q <= leds_in every cycle; 1-cycle latency. All other logic uses leds_q only.
- Prescaler: counts 0..CLK_DIV-1, then wraps to 0. tick=1 exactly in the cycle where count==CLK_DIV-1. With CLK_DIV=1, tick is 1 every cycle.
- Target: target[i] = leds_q[i] ? MAX : 0.
- Ramp, on tick, per LED:
  - leds_q[i]=1: level <= min(level+STEP, MAX).
  - leds_q[i]=0: level <= max(level-STEP, 0).
  - Use saturating arithmetic; compute in PWM_BITS+1 bits so there is no wrap.
  - With no tick, level holds.
- Direction reversal: if the target changes mid-ramp, the next tick moves from the current level in the new direction. Nothing is restarted.
- Simultaneous tick and leds_in change: the tick uses the registered leds_q (old value); the new value applies from the next tick.
- Bypass=1:
  - level[i] <= target[i] every cycle.
  - led_out <= leds_q.
  - Prescaler keeps running.
  - When bypass returns to 0, fading resumes from the snapped levels.
- PWM:
  - pwm_cnt free-runs 0..MAX and wraps.
  - led_out[i] is registered: led_out[i] <= (level[i]==MAX) | (pwm_cnt < level[i]).
  - Result: level 0 = always off; MAX = always on; level L = on for L of every 2^PWM_BITS cycles.
- settled: registered; settled <= AND over i of (level[i]==target[i]), evaluated on current (pre-update) values.
- settle_pulse <= settled_next & ~settled. Never asserted out of reset.
- Reset mid-ramp: levels return to 0 immediately. Ramp resumes from 0 after release.

Test Plan:
- Parameters for all scenarios: CLK_DIV=4, STEP=1, PWM_BITS=4 (MAX=15).
- 1. Reset with leds_in=0xFF, then release -> led_out=0x00, settled=1, settle_pulse=0 while reset is high. After release, level[*] reaches 15 after 15 ticks (60 cycles). settled=1 after that, with exactly one settle_pulse.
- 2. leds_in 0x00->0x01 -> settled falls within 3 cycles. Hold level[0]=5 (observe by pausing via a test-only check or by counting) -> led_out[0] high exactly 5 of 16 consecutive cycles; led_out[7:1]=0.
- 3. Ramp LED0 to 8, then set leds_in=0x00 -> on the next tick level=7, continuing down to 0. settle_pulse fires once at 0. No overshoot below 0.
- 4. STEP=4, leds_in=0x80 -> level[7] sequence 0,4,8,12,15,15 on successive ticks, saturating at 15. led_out[7] constant 1 once level=15.
- 5. Mid-ramp bypass=1 with leds_in=0xA5 -> two cycles later led_out=0xA5 exactly and settled=1. Drop bypass, set leds_in=0x5A -> fading resumes from 15/0 levels.
- 6. Assert reset_reset asynchronously mid-ramp, between clock edges -> led_out=0 and level=0 before the next edge. After release, behaviour is identical to scenario 1.
